// File: rtl/fb_mem_arbiter_pkg.sv
// rtl/fb_mem_arbiter_pkg.sv - shared encodings for the frame-buffer memory arbiter
package fb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_e;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    localparam logic OWN_RD = 1'b0;
    localparam logic OWN_WR = 1'b1;

    function automatic logic own_to_rw(input logic own);
        return (own == OWN_WR) ? MEM_WR : MEM_RD;
    endfunction

endpackage

// File: rtl/fb_arb_pick.sv
// rtl/fb_arb_pick.sv - combinational 2-way grant with urgent override and writer anti-starvation
module fb_arb_pick
    import fb_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             rd_req,
    input  logic             wr_req,
    input  logic             rd_urgent,
    input  logic             last_owner,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output logic             grant,
    output logic [CNT_W-1:0] starve_cnt_next
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    always_comb begin
        grant_valid     = rd_req | wr_req;
        grant           = OWN_RD;
        starve_cnt_next = '0;

        if (rd_req && !wr_req) begin
            grant = OWN_RD;
        end else if (wr_req && !rd_req) begin
            grant = OWN_WR;
        end else if (starve_cnt >= STARVE_LIM) begin
            grant = OWN_WR;
        end else if (rd_urgent) begin
            grant = OWN_RD;
        end else begin
            grant = ~last_owner;
        end

        // Only read grants that bypass a waiting writer count toward starvation.
        if (wr_req && (grant == OWN_RD)) begin
            if (starve_cnt < STARVE_LIM) begin
                starve_cnt_next = starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt_next = starve_cnt;
            end
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - sequencer sharing the 256-bit frame-buffer port between display reads and frame writes
module fb_mem_arbiter
    import fb_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 256,
    parameter int STARVE_MAX  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              rd_urgent,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_valid_data,
    output logic              mem_rw_data,
    output logic [ADDR_W-1:0] mem_data_addr,
    output logic [DATA_W-1:0] data_wr,
    input  logic [DATA_W-1:0] data_rd,
    input  logic              mem_ready_data,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TIMEOUT_CYC - 1);
    localparam logic [TC_W-1:0] TMO_SAT  = TC_W'(TIMEOUT_CYC);

    arb_state_e        state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] data_wr_q, data_wr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [TC_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic              pick_valid;
    logic              pick_grant;
    logic [SC_W-1:0]   pick_starve_next;

    fb_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (SC_W)
    ) u_pick (
        .rd_req          (rd_req),
        .wr_req          (wr_req),
        .rd_urgent       (rd_urgent),
        .last_owner      (last_owner_q),
        .starve_cnt      (starve_cnt_q),
        .grant_valid     (pick_valid),
        .grant           (pick_grant),
        .starve_cnt_next (pick_starve_next)
    );

    always_comb begin
        state_d       = state_q;
        mem_valid_d   = mem_valid_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        data_wr_d     = data_wr_q;
        rd_data_d     = rd_data_q;
        rd_ack_d      = 1'b0;
        wr_ack_d      = 1'b0;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        starve_cnt_d  = starve_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                starve_cnt_d = pick_starve_next;
                if (pick_valid) begin
                    state_d     = ST_ACCESS;
                    mem_valid_d = 1'b1;
                    mem_rw_d    = own_to_rw(pick_grant);
                    owner_d     = pick_grant;
                    if (pick_grant == OWN_WR) begin
                        mem_addr_d = wr_addr;
                        data_wr_d  = wr_data;
                    end else begin
                        mem_addr_d = rd_addr;
                    end
                end
            end
            ST_ACCESS: begin
                // The timeout only flags; the access keeps waiting for the memory.
                if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                end
                if (tmo_cnt_q != TMO_SAT) begin
                    tmo_cnt_d = tmo_cnt_q + TC_W'(1);
                end
                if (mem_ready_data) begin
                    if (mem_rw_q == MEM_RD) begin
                        rd_data_d = data_rd;
                    end
                    mem_valid_d = 1'b0;
                    rd_ack_d    = (owner_q == OWN_RD);
                    wr_ack_d    = (owner_q == OWN_WR);
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                last_owner_d = owner_q;
                tmo_cnt_d    = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mem_valid_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            data_wr_q     <= '0;
            rd_data_q     <= '0;
            rd_ack_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            owner_q       <= 1'b0;
            last_owner_q  <= OWN_WR;
            starve_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_valid_q   <= mem_valid_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            data_wr_q     <= data_wr_d;
            rd_data_q     <= rd_data_d;
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            starve_cnt_q  <= starve_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rd_ack         = rd_ack_q;
    assign wr_ack         = wr_ack_q;
    assign rd_data        = rd_data_q;
    assign mem_valid_data = mem_valid_q;
    assign mem_rw_data    = mem_rw_q;
    assign mem_data_addr  = mem_addr_q;
    assign data_wr        = data_wr_q;
    assign owner          = owner_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - directed and randomized checks of fb_mem_arbiter against a grant-rule model
module tb_fb_mem_arbiter;

    localparam int AW   = 28;
    localparam int DW   = 256;
    localparam int SMAX = 8;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req, rd_urgent, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data, data_rd;
    logic          mem_ready_data;
    logic          rd_ack, wr_ack, mem_valid_data, mem_rw_data, owner, busy, timeout_err;
    logic [AW-1:0] mem_data_addr;
    logic [DW-1:0] rd_data, data_wr;

    int n_chk  = 0;
    int n_fail = 0;

    bit            m_last_wr;
    int            m_starve;
    bit            m_err;
    int            rd_run;
    logic [DW-1:0] exp_rd_data;
    bit            g;

    fb_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_MAX  (SMAX),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_req         (rd_req),
        .rd_urgent      (rd_urgent),
        .rd_addr        (rd_addr),
        .rd_ack         (rd_ack),
        .rd_data        (rd_data),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .mem_valid_data (mem_valid_data),
        .mem_rw_data    (mem_rw_data),
        .mem_data_addr  (mem_data_addr),
        .data_wr        (data_wr),
        .data_rd        (data_rd),
        .mem_ready_data (mem_ready_data),
        .owner          (owner),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant rules in priority order: sole requester, starved writer, urgent reader, round-robin.
    function automatic bit model_pick();
        if (rd_req && !wr_req) return 1'b0;
        if (wr_req && !rd_req) return 1'b1;
        if (m_starve == SMAX) return 1'b1;
        if (rd_urgent) return 1'b0;
        return !m_last_wr;
    endfunction

    task automatic serve(input int lat, input bit ready_in_ack, output bit gw);
        logic [DW-1:0] d;
        gw = model_pick();
        if (!wr_req) m_starve = 0;
        else if (gw) m_starve = 0;
        else if (m_starve < SMAX) m_starve = m_starve + 1;
        @(posedge clk); #1;
        if (wr_req && owner == 1'b0) rd_run++;
        else rd_run = 0;
        chk1("wr_wait_le_max", (rd_run <= SMAX), 1'b1);
        chk1("grant_valid", mem_valid_data, 1'b1);
        chk1("grant_owner", owner, gw);
        chk1("grant_rw", mem_rw_data, !gw);
        chk1("grant_busy", busy, 1'b1);
        chkw("grant_addr", DW'(mem_data_addr), DW'(gw ? wr_addr : rd_addr));
        if (gw) chkw("grant_wdata", data_wr, wr_data);
        for (int j = 1; j <= lat; j++) begin
            @(posedge clk); #1;
            if (j >= TMO) m_err = 1'b1;
            chk1("access_valid_held", mem_valid_data, 1'b1);
            chk1("access_tmo_err", timeout_err, m_err);
        end
        d              = rnd256();
        data_rd        = d;
        mem_ready_data = 1'b1;
        @(posedge clk); #1;
        if (lat + 1 >= TMO) m_err = 1'b1;
        if (!gw) exp_rd_data = d;
        data_rd = rnd256();
        if (!ready_in_ack) mem_ready_data = 1'b0;
        chk1("ack_rd", rd_ack, !gw);
        chk1("ack_wr", wr_ack, gw);
        chk1("ack_valid_low", mem_valid_data, 1'b0);
        chkw("ack_rd_data", rd_data, exp_rd_data);
        chk1("ack_tmo_err", timeout_err, m_err);
        m_last_wr = gw;
        @(posedge clk); #1;
        mem_ready_data = 1'b0;
        chk1("post_ack_rd", rd_ack, 1'b0);
        chk1("post_ack_wr", wr_ack, 1'b0);
        chk1("post_ack_idle", busy, 1'b0);
        chkw("post_ack_rd_data", rd_data, exp_rd_data);
    endtask

    task automatic model_reset();
        m_last_wr   = 1'b1;
        m_starve    = 0;
        m_err       = 1'b0;
        rd_run      = 0;
        exp_rd_data = '0;
    endtask

    initial begin
        rst = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; data_rd = '0; mem_ready_data = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_valid", mem_valid_data, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_tmo", timeout_err, 1'b0);
        chkw("rst_rd_data", rd_data, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single read, ready one cycle after valid rises.
        rd_req  = 1'b1;
        rd_addr = 28'h0000100;
        serve(1, 1'b0, g);
        chk1("t1_is_rd", g, 1'b0);
        rd_req = 1'b0;

        // Ready pulses while idle are ignored.
        data_rd = rnd256(); mem_ready_data = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk1("idle_rdy_busy", busy, 1'b0);
            chk1("idle_rdy_valid", mem_valid_data, 1'b0);
            chk1("idle_rdy_rd_ack", rd_ack, 1'b0);
            chk1("idle_rdy_wr_ack", wr_ack, 1'b0);
            chkw("idle_rdy_rd_data", rd_data, exp_rd_data);
        end
        mem_ready_data = 1'b0;
        m_starve       = 0;

        // Both held, not urgent: round-robin.
        rd_req = 1'b1; wr_req = 1'b1; rd_urgent = 1'b0;
        rd_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = rnd256();
        for (int i = 0; i < 4; i++) begin
            serve($urandom_range(0, 2), 1'b0, g);
            if (g) begin wr_addr = AW'($urandom); wr_data = rnd256(); end
            else rd_addr = AW'($urandom);
        end

        // Urgent reader with a waiting writer: writer forced after STARVE_MAX reads.
        rd_urgent = 1'b1;
        for (int i = 0; i < 20; i++) begin
            serve(0, 1'b0, g);
            if (g) begin wr_addr = AW'($urandom); wr_data = rnd256(); end
            else rd_addr = AW'($urandom);
        end

        // Randomized traffic; only the acked requester may change its request.
        for (int i = 0; i < 40; i++) begin
            rd_urgent = 1'($urandom_range(0, 1));
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), g);
            if (g) begin
                wr_req = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom); wr_data = rnd256();
            end else begin
                rd_req = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom);
            end
            if (!rd_req && !wr_req) begin
                if ($urandom_range(0, 1) == 0) rd_req = 1'b1;
                else wr_req = 1'b1;
            end
        end

        // Memory stalls past the timeout, then a late ready completes the read.
        wr_req = 1'b0; rd_req = 1'b1; rd_urgent = 1'b0; rd_addr = AW'($urandom);
        serve(TMO + 4, 1'b1, g);
        chk1("t4_tmo_sticky", timeout_err, 1'b1);

        // Asynchronous reset in the middle of an access.
        @(posedge clk); #1;
        chk1("t5_valid_before", mem_valid_data, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk1("t5_valid", mem_valid_data, 1'b0);
        chk1("t5_rd_ack", rd_ack, 1'b0);
        chk1("t5_wr_ack", wr_ack, 1'b0);
        chk1("t5_tmo", timeout_err, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_owner", owner, 1'b0);
        chkw("t5_rd_data", rd_data, '0);
        model_reset();
        rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b1; wr_req = 1'b1; rd_urgent = 1'b0;
        rd_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = rnd256();
        serve(0, 1'b0, g);
        chk1("t5_first_tie_rd", owner, 1'b0);
        rd_addr = AW'($urandom);
        serve(1, 1'b0, g);
        chk1("t5_second_wr", owner, 1'b1);
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
